// File: rtl/rr_arbiter_n_pkg.sv
// Shared arbiter definitions: IDLE/BUSY state encoding and the CLogB2 width helper.
package rr_arbiter_n_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Number of bits needed to hold the value (minimum 1).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/rr_arbiter_n_decoder.sv
// Binary-to-one-hot decoder used to form the arbiter grant vector.
module rr_arbiter_n_decoder
    import rr_arbiter_n_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int IDW  = clogb2(SIZE - 1)
) (
    input  logic [IDW-1:0]  i_id,
    output logic [SIZE-1:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_dec
            assign o_onehot[gi] = (i_id == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with grant locking and back-to-back re-arbitration on release.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_n
    import rr_arbiter_n_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic [SIZE-1:0]               i_request,
    input  logic                          i_release,
    output logic [SIZE-1:0]               o_grant,
    output logic [clogb2(SIZE-1)-1:0]     o_grant_id,
    output logic                          o_grant_valid,
    output logic                          o_timeout
);

    localparam int IDW = clogb2(SIZE - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(SIZE - 1);

    arb_state_t     r_state, w_state_next;
    logic [IDW-1:0] r_ptr, w_ptr_next;
    logic [IDW-1:0] r_grant_id, w_grant_id_next;
    logic           r_grant_valid, w_grant_valid_next;
    logic [IDW-1:0] w_rel_ptr;
    logic [IDW:0]   w_pick;
    logic           w_free;
    logic           w_tmo_hit;
    logic [SIZE-1:0] w_dec;

    // Rotate the requests so the search origin lands at bit 0, take the lowest set bit,
    // then map the offset back to an index modulo SIZE. Returns {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [SIZE-1:0] req,
                                             input logic [IDW-1:0]  ptr);
        logic [SIZE-1:0] rot;
        logic [IDW:0]    off;
        logic [IDW:0]    sum;
        rot = SIZE'({req, req} >> ptr);
        off = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            if (rot[k]) off = (IDW+1)'(k);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDW+1)'(SIZE)) sum = sum - (IDW+1)'(SIZE);
        return {|req, sum[IDW-1:0]};
    endfunction

    assign w_rel_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
    assign w_free    = (r_state == ST_BUSY) && (i_release || w_tmo_hit);
    assign w_pick    = rr_pick(i_request, w_free ? w_rel_ptr : r_ptr);

    always_comb begin
        w_state_next       = r_state;
        w_ptr_next         = r_ptr;
        w_grant_id_next    = r_grant_id;
        w_grant_valid_next = r_grant_valid;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && w_pick[IDW]) begin
                    w_grant_id_next    = w_pick[IDW-1:0];
                    w_grant_valid_next = 1'b1;
                    w_state_next       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_free) begin
                    w_ptr_next = w_rel_ptr;
                    if (i_enable && w_pick[IDW]) begin
                        w_grant_id_next    = w_pick[IDW-1:0];
                        w_grant_valid_next = 1'b1;
                    end else begin
                        w_grant_valid_next = 1'b0;
                        w_state_next       = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next       = ST_IDLE;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_grant_id    <= w_grant_id_next;
            r_grant_valid <= w_grant_valid_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = clogb2(TIMEOUT);

    logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_next;
    logic          r_timeout;

    assign w_tmo_hit = (r_state == ST_BUSY) && !i_release &&
                       (r_tmo_cnt == TW'(TIMEOUT - 1));
    // Any release (real or forced) either starts a fresh grant or goes idle: both clear.
    assign w_tmo_cnt_next = (r_state == ST_BUSY && !w_free) ? r_tmo_cnt + 1'b1 : '0;
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_next;
            r_timeout <= w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

    rr_arbiter_n_decoder #(.SIZE(SIZE)) u_grant_dec (
        .i_id     (r_grant_id),
        .o_onehot (w_dec)
    );

    assign o_grant       = w_dec & {SIZE{r_grant_valid}};
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n (SIZE=4, TIMEOUT=4) against a behavioural model.
module tb_rr_arbiter_n;

    localparam int SIZE    = 4;
    localparam int TIMEOUT = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0;
    logic       en    = 1'b0;
    logic       rel   = 1'b0;
    logic [3:0] grant;
    logic [1:0] gid;
    logic       gv;
    logic       tmo;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy;
    int m_ptr;
    int m_id;
    int m_cnt;
    bit m_tmo;

    always #5 clk = ~clk;

    rr_arbiter_n #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_enable      (en),
        .i_request     (req),
        .i_release     (rel),
        .o_grant       (grant),
        .o_grant_id    (gid),
        .o_grant_valid (gv),
        .o_timeout     (tmo)
    );

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 0; k < SIZE; k++) begin
            int i;
            i = (from + k) % SIZE;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic e, input logic l);
        int w;
        bit free;
        m_tmo = 0;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (e && w >= 0) begin
                m_busy = 1; m_id = w; m_cnt = 0;
            end
        end else begin
            free = l;
`ifdef ARB_TIMEOUT_EN
            if (!l && m_cnt == TIMEOUT - 1) begin
                free = 1; m_tmo = 1;
            end
`endif
            if (free) begin
                m_ptr = (m_id + 1) % SIZE;
                w = pick(r, m_ptr);
                if (e && w >= 0) begin
                    m_id = w; m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [7:0] expv();
        logic [3:0] g;
        logic [1:0] id2;
        g   = m_busy ? (4'b0001 << m_id) : 4'b0000;
        id2 = m_id[1:0];
        return {g, id2, m_busy, m_tmo};
    endfunction

    task automatic cyc(input logic [3:0] r, input logic e, input logic l);
        req = r; en = e; rel = l;
        @(posedge clk);
        model_step(r, e, l);
        #1;
        $display("cyc req=%b en=%b rel=%b -> grant=%b id=%0d valid=%b timeout=%b",
                 r, e, l, grant, gid, gv, tmo);
    endtask

    task automatic do_reset();
        req = 4'b0; en = 1'b0; rel = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b0; en = 1'b0; rel = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        total++;
        if ({grant, gid, gv, tmo} !== 8'b0) begin
            bad++;
            $display("FAIL reset_state: got=%b exp=%b", {grant, gid, gv, tmo}, 8'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'b0000, 1'b1, 1'b0);
        total++;
        if ({grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL idle_no_req: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
    endtask

    task automatic test_first_grant();
        cyc(4'b1010, 1'b1, 1'b0);
        total++;
        if ({grant, gid, gv} !== {4'b0010, 2'd1, 1'b1} || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL first_grant: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
    endtask

    task automatic test_back_to_back();
        cyc(4'b1010, 1'b1, 1'b1);
        total++;
        if (grant !== 4'b1000 || gid !== 2'd3 || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL b2b_next: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
        cyc(4'b1010, 1'b1, 1'b1);
        total++;
        if (grant !== 4'b0010 || gv !== 1'b1 || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL b2b_wrap: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
    endtask

    task automatic test_lock();
        int hold;
`ifdef ARB_TIMEOUT_EN
        hold = TIMEOUT - 2;
`else
        hold = 10;
`endif
        do_reset();
        cyc(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < hold; i++) begin
            cyc(4'b1011, 1'b1, 1'b0);
            total++;
            if (grant !== 4'b0100 || {grant, gid, gv, tmo} !== expv()) begin
                bad++;
                $display("FAIL lock_hold[%0d]: got=%b exp=%b", i, {grant, gid, gv, tmo}, expv());
            end
        end
        cyc(4'b0000, 1'b1, 1'b1);
        total++;
        if (gv !== 1'b0 || grant !== 4'b0000 || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL lock_release_idle: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(4'b1111, 1'b0, 1'b0);
            total++;
            if (gv !== 1'b0 || {grant, gid, gv, tmo} !== expv()) begin
                bad++;
                $display("FAIL enable_off[%0d]: got=%b exp=%b", i, {grant, gid, gv, tmo}, expv());
            end
        end
        cyc(4'b1111, 1'b1, 1'b0);
        total++;
        if (grant !== 4'b0001 || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL enable_on: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b0, 1'b0);
            total++;
            if (grant !== 4'b0001 || {grant, gid, gv, tmo} !== expv()) begin
                bad++;
                $display("FAIL enable_drop_hold[%0d]: got=%b exp=%b", i, {grant, gid, gv, tmo}, expv());
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(4'b0100, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({grant, gid, gv} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset: got=%b exp=%b", {grant, gid, gv}, 7'b0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'b1000, 1'b1, 1'b0);
        total++;
        if (gid !== 2'd3 || {grant, gid, gv, tmo} !== expv()) begin
            bad++;
            $display("FAIL after_reset_grant: got=%b exp=%b", {grant, gid, gv, tmo}, expv());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0011, 1'b1, 1'b0);
            total++;
            if ({grant, gid, gv, tmo} !== expv()) begin
                bad++;
                $display("FAIL timeout_seq[%0d]: got=%b exp=%b", i, {grant, gid, gv, tmo}, expv());
            end
`ifdef ARB_TIMEOUT_EN
            if (i == 3) begin
                total++;
                if (tmo !== 1'b1 || grant !== 4'b0010) begin
                    bad++;
                    $display("FAIL timeout_fire: got tmo=%b grant=%b exp tmo=1 grant=0010", tmo, grant);
                end
            end
`else
            total++;
            if (tmo !== 1'b0 || grant !== 4'b0001) begin
                bad++;
                $display("FAIL timeout_absent[%0d]: got tmo=%b grant=%b exp tmo=0 grant=0001", i, tmo, grant);
            end
`endif
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic e, l;
            r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            cyc(r, e, l);
            total++;
            if ({grant, gid, gv, tmo} !== expv()) begin
                bad++;
                $display("FAIL random[%0d]: got=%b exp=%b", i, {grant, gid, gv, tmo}, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_lock();
        test_enable();
        test_async_reset();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
